// File: rtl/com_to_fifo.sv
// UART receive path: deserialises 8N1 frames into data/CRC-8 byte pairs,
// verifies the CRC and pushes good data bytes into the receive FIFO.
module com_to_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_enable,
    input  logic       i_rx,
    input  logic       i_fifo_busy,
    input  logic       i_fifo_full,
    output logic       o_fifo_we,
    output logic [7:0] o_fifo_data,
    output logic [7:0] o_data_out,
    output logic [7:0] o_crc_out,
    output logic       o_crc_error,
    output logic       o_frame_error,
    output logic       o_overflow,
    output logic       o_isFinish,
    output logic       o_busy
);

    localparam int CNT_W      = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_CYCLES  = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W       = $clog2(TO_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_CHECK = 3'd4,
        S_WRITE = 3'd5,
        S_BREAK = 3'd6
    } state_t;

    // CRC-8, poly 0x07, init 0x00, MSB first; over a single byte the init is the byte itself
    function automatic logic [7:0] crc8(input logic [7:0] d);
        logic [7:0] c;
        c = d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    logic             r_rx_meta;
    logic             r_rx_sync;
    state_t           r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_pending;
    logic [TO_W-1:0]  r_to_cnt;
    logic [7:0]       r_data_out;
    logic [7:0]       r_crc_out;
    logic [7:0]       r_fifo_data;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       w_idx_next;
    logic [7:0]       w_shift_next;
    logic             w_pending_next;
    logic [TO_W-1:0]  w_to_next;
    logic [7:0]       w_dout_next;
    logic [7:0]       w_cout_next;
    logic             w_we;
    logic             w_crc_err;
    logic             w_frm_err;
    logic             w_ovf;
    logic             w_fin;
    logic             w_crc_match;
    logic             w_we_g;

    assign w_crc_match = (crc8(r_data_out) == r_shift);

    // Two-flop synchroniser for the asynchronous serial line, idle high
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Next-state and pulse decode for the receive/check/write sequence
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_bit_cnt;
        w_idx_next     = r_bit_idx;
        w_shift_next   = r_shift;
        w_pending_next = r_pending;
        w_to_next      = r_to_cnt;
        w_dout_next    = r_data_out;
        w_cout_next    = r_crc_out;
        w_we           = 1'b0;
        w_crc_err      = 1'b0;
        w_frm_err      = 1'b0;
        w_ovf          = 1'b0;
        w_fin          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_pending && (r_to_cnt == TO_LAST)) begin
                    w_pending_next = 1'b0;
                    w_to_next      = '0;
                    w_fin          = 1'b1;
                end else if (r_pending) begin
                    w_to_next = r_to_cnt + TO_ONE;
                end else begin
                    w_to_next = '0;
                end
                if (!r_rx_sync) begin
                    w_state_next = S_START;
                    w_cnt_next   = CNT_ONE;
                end else begin
                    w_cnt_next = '0;
                end
            end
            S_START: begin
                if (r_bit_cnt == CNT_HALF) begin
                    w_cnt_next = CNT_ONE;
                    w_idx_next = 3'd0;
                    w_state_next = r_rx_sync ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_next = r_bit_cnt + CNT_ONE;
                end
            end
            S_DATA: begin
                if (r_bit_cnt == CNT_FULL) begin
                    w_cnt_next   = CNT_ONE;
                    w_shift_next = {r_rx_sync, r_shift[7:1]};
                    w_idx_next   = r_bit_idx + 3'd1;
                    w_state_next = (r_bit_idx == 3'd7) ? S_STOP : S_DATA;
                end else begin
                    w_cnt_next = r_bit_cnt + CNT_ONE;
                end
            end
            S_STOP: begin
                if ((r_bit_cnt == CNT_FULL) && r_rx_sync) begin
                    w_state_next = S_CHECK;
                end else if (r_bit_cnt == CNT_FULL) begin
                    w_frm_err      = 1'b1;
                    w_fin          = 1'b1;
                    w_pending_next = 1'b0;
                    w_state_next   = S_BREAK;
                end else begin
                    w_cnt_next = r_bit_cnt + CNT_ONE;
                end
            end
            S_CHECK: begin
                w_cnt_next = '0;
                if (!r_pending) begin
                    w_dout_next    = r_shift;
                    w_pending_next = 1'b1;
                    w_to_next      = '0;
                    w_state_next   = S_IDLE;
                end else if (w_crc_match) begin
                    w_cout_next    = r_shift;
                    w_pending_next = 1'b0;
                    w_state_next   = S_WRITE;
                end else begin
                    w_cout_next    = r_shift;
                    w_pending_next = 1'b0;
                    w_crc_err      = 1'b1;
                    w_fin          = 1'b1;
                    w_state_next   = S_IDLE;
                end
            end
            S_WRITE: begin
                // Full has priority; a busy FIFO is given half a bit-time before the byte is dropped
                if (i_fifo_full) begin
                    w_ovf        = 1'b1;
                    w_fin        = 1'b1;
                    w_state_next = S_IDLE;
                end else if (!i_fifo_busy) begin
                    w_we         = 1'b1;
                    w_fin        = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_bit_cnt == CNT_HALF) begin
                    w_ovf        = 1'b1;
                    w_fin        = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_bit_cnt + CNT_ONE;
                end
            end
            S_BREAK: begin
                w_state_next = r_rx_sync ? S_IDLE : S_BREAK;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, datapath and display registers; enable low parks the receiver
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_pending   <= 1'b0;
            r_to_cnt    <= '0;
            r_data_out  <= 8'h00;
            r_crc_out   <= 8'h00;
            r_fifo_data <= 8'h00;
        end else if (!i_enable) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_pending <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_bit_cnt  <= w_cnt_next;
            r_bit_idx  <= w_idx_next;
            r_shift    <= w_shift_next;
            r_pending  <= w_pending_next;
            r_to_cnt   <= w_to_next;
            r_data_out <= w_dout_next;
            r_crc_out  <= w_cout_next;
            if (w_we_g) begin
                r_fifo_data <= r_data_out;
            end else begin
                r_fifo_data <= r_fifo_data;
            end
        end
    end

    assign w_we_g        = w_we & i_enable;
    assign o_fifo_we     = w_we_g;
    assign o_fifo_data   = w_we_g ? r_data_out : r_fifo_data;
    assign o_data_out    = r_data_out;
    assign o_crc_out     = r_crc_out;
    assign o_crc_error   = w_crc_err & i_enable;
    assign o_frame_error = w_frm_err & i_enable;
    assign o_overflow    = w_ovf & i_enable;
    assign o_isFinish    = w_fin & i_enable;
    assign o_busy        = (r_state != S_IDLE) | r_pending;

endmodule

// File: doc/com_to_fifo.md
# com_to_fifo

Serial receive path for the board's UART link: deserialises 8N1 frames from `rx` into two-byte packets (data byte, then its CRC-8), checks the CRC, and pushes each good data byte into the receive FIFO through the same `we`/`busy` write port the transmit-side loader drives. It is the counterpart of the FIFO→UART transmit chain, so two boards can exchange CRC-protected bytes. Status pulses feed the seven-segment/LED debug logic.

## Interface
- `CLKS_PER_BIT`, 16: `clk` cycles per UART bit; even, ≥ 8.
- `TIMEOUT_BITS`, 20: idle bit-times allowed between data byte and CRC byte before the packet is dropped.
- `clk` input 1: UART-rate clock; all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `enable` input 1: synchronous run enable; low forces IDLE and clears the pending packet.
- `rx` input 1: asynchronous serial line, idle high.
- `fifo_busy` input 1: FIFO cannot accept a write this cycle.
- `fifo_full` input 1: FIFO full.
- `fifo_we` output 1: one-cycle write strobe.
- `fifo_data` output 8: byte written; valid while `fifo_we` is high, held afterwards.
- `data_out` output 8: last received data byte (display).
- `crc_out` output 8: last received CRC byte (display).
- `crc_error` output 1: one-cycle pulse, CRC mismatch.
- `frame_error` output 1: one-cycle pulse, stop bit sampled low.
- `overflow` output 1: one-cycle pulse, good byte dropped (FIFO full/busy).
- `isFinish` output 1: one-cycle pulse when a packet is fully handled (written, or dropped for any reason).
- `busy` output 1: high whenever state ≠ IDLE or a data byte is pending.

## Operation
- `rx` passes through a 2-flop synchroniser (both flops reset to 1); all references to `rx` below mean the synchronised value.
- States: IDLE, START, DATA, STOP, CHECK, WRITE, BREAK.
- IDLE: falling edge of `rx` → START, bit counter cleared.
- START: at `CLKS_PER_BIT/2` cycles sample `rx`; high → IDLE (glitch, no pulse), low → DATA.
- DATA: sample every `CLKS_PER_BIT` cycles; 8 bits, LSB first, shifted into the byte register → STOP after bit 7.
- STOP: sample one bit-time later. Low → `frame_error` pulse, `isFinish` pulse, pending packet discarded, → BREAK. High → CHECK.
- BREAK: wait until `rx` is high, then → IDLE.
- CHECK, pending flag clear: byte → `data_out`, set pending, start timeout counter, → IDLE. Pending flag set: byte → `crc_out`, clear pending; CRC-8 (poly 0x07, init 0x00, MSB first, no reflect, no final XOR) of `data_out` equal → WRITE, else `crc_error` + `isFinish` pulses, → IDLE.
- WRITE: `fifo_full` → `overflow` + `isFinish`, → IDLE. Else if `!fifo_busy` → `fifo_we`=1 with `fifo_data`=`data_out`, `isFinish`, → IDLE. Busy for more than `CLKS_PER_BIT/2` consecutive cycles → `overflow` + `isFinish`, → IDLE.
- Timeout: pending set and IDLE for `TIMEOUT_BITS*CLKS_PER_BIT` cycles → clear pending, `isFinish` pulse (no error pulse).
- `enable` low: next cycle state = IDLE, pending cleared, all pulses 0; `data_out`/`crc_out`/`fifo_data` hold.
- At most one of `crc_error`, `frame_error`, `overflow` per cycle.

## Timing
- Reset values: all outputs 0; `data_out`, `crc_out`, `fifo_data` = 0x00; state IDLE; pending clear.
- Reset asserted mid-frame: immediate return to reset values; first frame after release requires a fresh falling edge.
- Let E = first cycle synchronised `rx` is low. Start sample at E+`CLKS_PER_BIT/2`; data bit k at E+`CLKS_PER_BIT/2`+(k+1)·`CLKS_PER_BIT`; stop sample S = E+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT` (E+152 at default).
- CHECK at S+1; `fifo_we` earliest at S+2 (same cycle as `isFinish`).
- Back-to-back frames: IDLE re-entered by S+3 worst-case non-busy, so a start bit beginning half a bit after the stop sample is caught.
- `fifo_we` never asserted in a cycle where `fifo_busy` or `fifo_full` is high.

## Test plan
- Frame 0x01 then 0x07, FIFO idle → one `fifo_we` at S+2 of second frame, `fifo_data`=0x01, `crc_out`=0x07, no error pulses.
- Frame 0x80 then 0x88 → `crc_error` one cycle, no `fifo_we`, `data_out`=0x80, `crc_out`=0x88.
- Frame 0x55 with stop bit forced low, then line high, then 0x80/0x89 → `frame_error` once; following packet writes 0x80.
- `fifo_full`=1 during good packet 0x01/0x07 → `overflow` pulse, no `fifo_we`; `fifo_busy` held 4 cycles then released → write on 5th cycle.
- 4-cycle low glitch on idle `rx` → no state change, no pulses; data byte 0x01 then silence for 20 bit-times → pending cleared, `isFinish` pulse, next lone 0x07 treated as data.
- `reset_n` low in middle of DATA → all outputs 0x00/0 immediately; subsequent packet 0x80/0x89 written correctly.
